// File: rtl/uart_tx.sv
// ULX3S UART transmitter demo: repeatedly sends "Hello, ULX3S!\r\n" as 8N1 frames,
// with an idle gap after each message and the current byte shown on the LEDs.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int GAP_CLKS     = 25000
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    output logic       ftdi_txd,
    output logic [7:0] led
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CLKS - 1);
    localparam logic [3:0]    LAST_INDEX = 4'd14;

    typedef enum logic [2:0] {
        WAIT,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [BW-1:0] baud;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    index;
    logic [7:0]    shift;
    logic          bit_end;
    logic          gap_end;
    logic          txd_next;

    function automatic logic [7:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = 8'h48;
            4'd1:    rom = 8'h65;
            4'd2:    rom = 8'h6C;
            4'd3:    rom = 8'h6C;
            4'd4:    rom = 8'h6F;
            4'd5:    rom = 8'h2C;
            4'd6:    rom = 8'h20;
            4'd7:    rom = 8'h55;
            4'd8:    rom = 8'h4C;
            4'd9:    rom = 8'h58;
            4'd10:   rom = 8'h33;
            4'd11:   rom = 8'h53;
            4'd12:   rom = 8'h21;
            4'd13:   rom = 8'h0D;
            4'd14:   rom = 8'h0A;
            default: rom = 8'h00;
        endcase
    endfunction

    assign bit_end = (baud == BAUD_LAST);
    assign gap_end = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        txd_next   = 1'b1;
        case (state)
            WAIT: begin
                if (bit_end) next_state = START;
            end
            START: begin
                txd_next = 1'b0;
                if (bit_end) next_state = DATA;
            end
            DATA: begin
                txd_next = shift[0];
                if (bit_end && bit_cnt == 3'd7) next_state = STOP;
            end
            STOP: begin
                if (bit_end) next_state = (index == LAST_INDEX) ? GAP : START;
            end
            GAP: begin
                if (gap_end) next_state = START;
            end
            default: next_state = WAIT;
        endcase
    end

    // The line is registered from the current state, so it lags the state by one
    // cycle and the start bit lands on the same edge that loads the LEDs.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            ftdi_txd <= 1'b1;
            led      <= 8'h00;
            baud     <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= 3'd0;
            index    <= 4'd0;
            shift    <= 8'h00;
        end else begin
            ftdi_txd <= txd_next;
            baud     <= (state == GAP || bit_end) ? '0 : baud + BW'(1);
            gap_cnt  <= (state == GAP && !gap_end) ? gap_cnt + GW'(1) : '0;

            if (state == DATA) begin
                if (bit_end) bit_cnt <= bit_cnt + 3'd1;
            end else begin
                bit_cnt <= 3'd0;
            end

            if (state == START && baud == '0) begin
                shift <= rom(index);
                led   <= rom(index);
            end else if (state == DATA && bit_end) begin
                shift <= {1'b0, shift[7:1]};
            end

            if (state == STOP && bit_end && index != LAST_INDEX) begin
                index <= index + 4'd1;
            end else if ((state == GAP && gap_end) || state == WAIT) begin
                index <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx, run with shortened bit and gap lengths so a
// multi-message soak fits in a short simulation.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 8;
    localparam int GAP = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ftdi_txd;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h55,
                             8'h4C, 8'h58, 8'h33, 8'h53, 8'h21, 8'h0D, 8'h0A};

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .GAP_CLKS    (GAP)
    ) dut (
        .clk_25mhz(clk),
        .rst_n    (rst_n),
        .ftdi_txd (ftdi_txd),
        .led      (led)
    );

    always #20 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until the line is first seen low.
    task automatic wait_start(input int limit, output int waited, output bit found);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < limit) begin
            tick(1);
            waited++;
            if (ftdi_txd === 1'b0) found = 1'b1;
        end
    endtask

    // Entered on the first low cycle of a start bit; leaves at the middle of the stop bit.
    task automatic decode_frame(output logic [9:0] bits);
        tick(CPB / 2);
        bits[0] = ftdi_txd;
        for (int k = 1; k < 10; k++) begin
            tick(CPB);
            bits[k] = ftdi_txd;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (ftdi_txd !== 1'b1 || led !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_hold: txd=%b led=%h, expected txd=1 led=00", ftdi_txd, led);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < CPB; i++) begin
            tick(1);
            checks++;
            if (ftdi_txd !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: txd=%b, expected 1", i, ftdi_txd);
            end
        end
        tick(1);
        checks++;
        if (ftdi_txd !== 1'b0 || led !== 8'h48) begin
            errors++;
            $display("[TB] FAIL first_start: txd=%b led=%h, expected txd=0 led=48", ftdi_txd, led);
        end
    endtask

    task automatic test_first_frame;
        logic [9:0] bits;
        decode_frame(bits);
        checks++;
        if (bits !== 10'b1_0100_1000_0) begin
            errors++;
            $display("[TB] FAIL first_frame: bits=%b, expected %b", bits, 10'b1_0100_1000_0);
        end
        checks++;
        if (led !== 8'h48) begin
            errors++;
            $display("[TB] FAIL first_frame_led: led=%h, expected 48", led);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits;
        tick(CPB / 2 - 1);
        checks++;
        if (ftdi_txd !== 1'b1 || led !== 8'h48) begin
            errors++;
            $display("[TB] FAIL b2b_last_stop: txd=%b led=%h, expected txd=1 led=48", ftdi_txd, led);
        end
        tick(1);
        checks++;
        if (ftdi_txd !== 1'b0 || led !== 8'h65) begin
            errors++;
            $display("[TB] FAIL b2b_start: txd=%b led=%h, expected txd=0 led=65", ftdi_txd, led);
        end
        decode_frame(bits);
        checks++;
        if (bits !== {1'b1, 8'h65, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_frame: bits=%b, expected %b", bits, {1'b1, 8'h65, 1'b0});
        end
    endtask

    task automatic test_message_wrap;
        logic [9:0] bits;
        int         waited;
        bit         found;
        for (int i = 2; i < 15; i++) begin
            wait_start(2 * CPB, waited, found);
            checks++;
            if (!found || waited != CPB / 2) begin
                errors++;
                $display("[TB] FAIL wrap_spacing byte %0d: waited=%0d found=%0b, expected %0d", i, waited, found, CPB / 2);
            end
            decode_frame(bits);
            checks++;
            if (bits !== {1'b1, msg[i], 1'b0}) begin
                errors++;
                $display("[TB] FAIL wrap_byte %0d: bits=%b, expected %b", i, bits, {1'b1, msg[i], 1'b0});
            end
        end
        tick(CPB / 2 + GAP / 2);
        checks++;
        if (ftdi_txd !== 1'b1 || led !== 8'h0A) begin
            errors++;
            $display("[TB] FAIL wrap_gap: txd=%b led=%h, expected txd=1 led=0a", ftdi_txd, led);
        end
        wait_start(GAP + 2 * CPB, waited, found);
        checks++;
        if (!found || waited != GAP - GAP / 2) begin
            errors++;
            $display("[TB] FAIL wrap_gap_len: waited=%0d found=%0b, expected %0d", waited, found, GAP - GAP / 2);
        end
        checks++;
        if (led !== 8'h48) begin
            errors++;
            $display("[TB] FAIL wrap_led: led=%h, expected 48", led);
        end
        decode_frame(bits);
        checks++;
        if (bits !== {1'b1, 8'h48, 1'b0}) begin
            errors++;
            $display("[TB] FAIL wrap_restart: bits=%b, expected %b", bits, {1'b1, 8'h48, 1'b0});
        end
    endtask

    task automatic test_mid_frame_reset;
        logic [9:0] bits;
        int         waited;
        bit         found;
        wait_start(2 * CPB, waited, found);
        decode_frame(bits);
        wait_start(2 * CPB, waited, found);
        checks++;
        if (!found || led !== 8'h6C) begin
            errors++;
            $display("[TB] FAIL mfr_locate: found=%0b led=%h, expected found=1 led=6c", found, led);
        end
        tick(4 * CPB + 2);
        checks++;
        if (ftdi_txd !== 1'b1 || led !== 8'h6C) begin
            errors++;
            $display("[TB] FAIL mfr_bit3: txd=%b led=%h, expected txd=1 led=6c", ftdi_txd, led);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ftdi_txd !== 1'b1 || led !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mfr_async: txd=%b led=%h, expected txd=1 led=00", ftdi_txd, led);
        end
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < CPB; i++) begin
            tick(1);
            checks++;
            if (ftdi_txd !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mfr_idle cycle %0d: txd=%b, expected 1", i, ftdi_txd);
            end
        end
        tick(1);
        checks++;
        if (ftdi_txd !== 1'b0 || led !== 8'h48) begin
            errors++;
            $display("[TB] FAIL mfr_restart: txd=%b led=%h, expected txd=0 led=48", ftdi_txd, led);
        end
    endtask

    task automatic test_soak;
        logic [9:0] bits;
        int         waited;
        bit         found;
        int         pos = 0;
        int         msgs_ok = 0;
        bit         clean = 1'b1;
        bit         lost = 1'b0;
        for (int f = 0; f < 15 * 12 && !lost; f++) begin
            if (f > 0) begin
                wait_start(GAP + 2 * CPB, waited, found);
                checks++;
                if (!found || waited != ((pos == 0) ? CPB / 2 + GAP : CPB / 2)) begin
                    errors++;
                    clean = 1'b0;
                    $display("[TB] FAIL soak_spacing frame %0d: waited=%0d found=%0b", f, waited, found);
                    if (!found) lost = 1'b1;
                end
            end
            if (!lost) begin
                decode_frame(bits);
                checks++;
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                    errors++;
                    clean = 1'b0;
                    $display("[TB] FAIL soak_framing frame %0d: start=%b stop=%b, expected 0 and 1", f, bits[0], bits[9]);
                end
                checks++;
                if (bits[8:1] !== msg[pos]) begin
                    errors++;
                    clean = 1'b0;
                    $display("[TB] FAIL soak_byte frame %0d: got %h, expected %h", f, bits[8:1], msg[pos]);
                end
                if (pos == 14) begin
                    if (clean) msgs_ok++;
                    clean = 1'b1;
                    pos   = 0;
                end else begin
                    pos++;
                end
            end
        end
        checks++;
        if (msgs_ok != 12) begin
            errors++;
            $display("[TB] FAIL soak_messages: got %0d clean messages, expected 12", msgs_ok);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_message_wrap();
        test_mid_frame_reset();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
